bwd_ctrl: RTL and testbench

BWD_CTRL -- requirements
Module: bwd_ctrl

---
 rtl/bwd_ctrl.sv | 209 ++++++++++++++++++++
 tb/tb_bwd_ctrl.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bwd_ctrl.sv
// bwd_ctrl: sequences one backward pass of the gradient engine.
// Clears the engine, feeds NUM_UNKNOWNS initial guesses, collects results.
//
// Ports:
//   CLK, RESET           clock, asynchronous active-high reset
//   START                request one pass (honoured only in IDLE)
//   IN_VALID/READY/DATA  initial-guess stream (valid/ready handshake)
//   ENG_SCALER           registered scalar driven into the engine
//   ENG_CLEAR            engine accumulator clear (CLEAR state or RESET)
//   ENG_RESULT           engine accumulated result
//   OUT_VALID/DATA/INDEX gradient stream, no backpressure
//   BUSY, DONE           pass in progress / one-cycle completion pulse
//   STALL_CNT            only with BWD_CTRL_STALL_CNT_EN: FEED cycles
//                        spent waiting on IN_VALID, saturating at 0xFFFF
//
// Optional feature macro: BWD_CTRL_STALL_CNT_EN

module bwd_ctrl #(
    parameter int NUM_UNKNOWNS = 2,
    parameter int NUM_NONLIN   = 1,
    parameter int BIT_WIDTH    = 32,
    parameter int EXTRA_BITS   = 2,
    parameter int PIPE_LAT     = NUM_UNKNOWNS + NUM_NONLIN,
    localparam int W  = BIT_WIDTH + EXTRA_BITS,
    localparam int IW = (NUM_UNKNOWNS > 1) ? $clog2(NUM_UNKNOWNS) : 1
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          START,
    input  logic          IN_VALID,
    output logic          IN_READY,
    input  logic [W-1:0]  IN_DATA,
    output logic [W-1:0]  ENG_SCALER,
    output logic          ENG_CLEAR,
    input  logic [W-1:0]  ENG_RESULT,
    output logic          OUT_VALID,
    output logic [W-1:0]  OUT_DATA,
    output logic [IW-1:0] OUT_INDEX,
    output logic          BUSY,
`ifdef BWD_CTRL_STALL_CNT_EN
    output logic          DONE,
    output logic [15:0]   STALL_CNT
`else
    output logic          DONE
`endif
);

    // Counters must be able to hold NUM_UNKNOWNS itself.
    localparam int CW = $clog2(NUM_UNKNOWNS + 1);
    localparam logic [CW-1:0] NU    = CW'(NUM_UNKNOWNS);
    localparam logic [CW-1:0] NU_M1 = CW'(NUM_UNKNOWNS - 1);
    localparam logic [CW-1:0] ONE   = CW'(1);

    if (EXTRA_BITS != 0 && EXTRA_BITS != 2) begin : g_bad_extra
        $error("bwd_ctrl: EXTRA_BITS must be 0 or 2");
    end
    if (PIPE_LAT < 1) begin : g_bad_lat
        $error("bwd_ctrl: PIPE_LAT must be at least 1");
    end
    if (NUM_UNKNOWNS < 1) begin : g_bad_nu
        $error("bwd_ctrl: NUM_UNKNOWNS must be at least 1");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FEED,
        S_DRAIN,
        S_DONE
    } state_e;

    state_e state_q, state_d;

    logic [CW-1:0]       feed_cnt_q, feed_cnt_d;
    logic [CW-1:0]       out_cnt_q, out_cnt_d;
    logic [W-1:0]        scaler_q, scaler_d;
    logic [PIPE_LAT-1:0] tok_q, tok_d;
    logic [PIPE_LAT:0]   tok_sh;

    logic in_rdy;
    logic eng_clr;
    logic busy;
    logic done;
    logic hs;
    logic tok_out;
    logic last_in;
    logic last_out;

    assign hs       = IN_VALID & in_rdy;
    assign tok_out  = tok_q[PIPE_LAT-1];
    assign last_in  = hs && (feed_cnt_q == NU_M1);
    assign last_out = tok_out && (out_cnt_q == NU_M1);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    // FEED leaves on the edge that accepts the last beat, so with
    // PIPE_LAT=1 the final result still lands in DRAIN.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (START) state_d = S_CLEAR;
            S_CLEAR: state_d = S_FEED;
            S_FEED:  if (last_in) state_d = S_DRAIN;
            S_DRAIN: if (last_out) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        in_rdy  = 1'b0;
        eng_clr = 1'b0;
        busy    = 1'b1;
        done    = 1'b0;
        unique case (state_q)
            S_IDLE:  busy = 1'b0;
            S_CLEAR: eng_clr = 1'b1;
            S_FEED:  in_rdy = (feed_cnt_q < NU);
            S_DRAIN: busy = 1'b1;
            S_DONE:  done = 1'b1;
            default: busy = 1'b0;
        endcase
    end

    // ---------------- datapath next state ----------------
    always_comb begin
        feed_cnt_d = feed_cnt_q;
        out_cnt_d  = out_cnt_q;
        scaler_d   = scaler_q;
        if (state_q == S_CLEAR || state_q == S_DONE) begin
            feed_cnt_d = '0;
            out_cnt_d  = '0;
        end else begin
            if (hs) begin
                feed_cnt_d = feed_cnt_q + ONE;
            end
            if (tok_out) begin
                out_cnt_d = out_cnt_q + ONE;
            end
        end
        if (hs) begin
            scaler_d = IN_DATA;
        end
    end

    // One token per accepted beat marks when its result is due.
    always_comb begin
        tok_sh = {tok_q, hs};
        tok_d  = tok_sh[PIPE_LAT-1:0];
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            feed_cnt_q <= '0;
            out_cnt_q  <= '0;
            scaler_q   <= '0;
            tok_q      <= '0;
        end else begin
            feed_cnt_q <= feed_cnt_d;
            out_cnt_q  <= out_cnt_d;
            scaler_q   <= scaler_d;
            tok_q      <= tok_d;
        end
    end

`ifdef BWD_CTRL_STALL_CNT_EN
    logic [15:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (state_q == S_CLEAR) begin
            stall_d = '0;
        end else if (in_rdy && !IN_VALID && stall_q != 16'hFFFF) begin
            stall_d = stall_q + 16'd1;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign STALL_CNT = stall_q;
`endif

    // ---------------- outputs ----------------
    // Result fields are gated so they read zero outside a valid beat.
    assign IN_READY   = in_rdy;
    assign ENG_CLEAR  = eng_clr | RESET;
    assign ENG_SCALER = scaler_q;
    assign OUT_VALID  = tok_out;
    assign OUT_DATA   = tok_out ? ENG_RESULT : '0;
    assign OUT_INDEX  = tok_out ? out_cnt_q[IW-1:0] : '0;
    assign BUSY       = busy;
    assign DONE       = done;

endmodule

// File: tb/tb_bwd_ctrl.sv
// tb_bwd_ctrl: randomized and directed checks of bwd_ctrl against a
// timeline model (two instances: defaults, and 4 unknowns / latency 1).

module tb_bwd_ctrl;

    localparam int W = 34;

    logic         CLK = 1'b0;
    logic         RESET = 1'b1;
    logic         START = 1'b0;
    logic         IN_VALID = 1'b0;
    logic [W-1:0] IN_DATA = '0;
    logic [W-1:0] ENG_RESULT = '0;

    logic         rdy0, clr0, ov0, busy0, done0;
    logic [W-1:0] sc0, od0;
    logic [0:0]   ix0;
    logic         rdy1, clr1, ov1, busy1, done1;
    logic [W-1:0] sc1, od1;
    logic [1:0]   ix1;
    logic [15:0]  st0, st1;

    always #5 CLK = ~CLK;

    bwd_ctrl u_dut0 (
        .CLK        (CLK),
        .RESET      (RESET),
        .START      (START),
        .IN_VALID   (IN_VALID),
        .IN_READY   (rdy0),
        .IN_DATA    (IN_DATA),
        .ENG_SCALER (sc0),
        .ENG_CLEAR  (clr0),
        .ENG_RESULT (ENG_RESULT),
        .OUT_VALID  (ov0),
        .OUT_DATA   (od0),
        .OUT_INDEX  (ix0),
        .BUSY       (busy0),
`ifdef BWD_CTRL_STALL_CNT_EN
        .DONE       (done0),
        .STALL_CNT  (st0)
`else
        .DONE       (done0)
`endif
    );

    bwd_ctrl #(
        .NUM_UNKNOWNS (4),
        .PIPE_LAT     (1)
    ) u_dut1 (
        .CLK        (CLK),
        .RESET      (RESET),
        .START      (START),
        .IN_VALID   (IN_VALID),
        .IN_READY   (rdy1),
        .IN_DATA    (IN_DATA),
        .ENG_SCALER (sc1),
        .ENG_CLEAR  (clr1),
        .ENG_RESULT (ENG_RESULT),
        .OUT_VALID  (ov1),
        .OUT_DATA   (od1),
        .OUT_INDEX  (ix1),
        .BUSY       (busy1),
`ifdef BWD_CTRL_STALL_CNT_EN
        .DONE       (done1),
        .STALL_CNT  (st1)
`else
        .DONE       (done1)
`endif
    );

`ifndef BWD_CTRL_STALL_CNT_EN
    assign st0 = '0;
    assign st1 = '0;
`endif

    int n_chk = 0;
    int n_bad = 0;
    int cyc = 0;

    // Model: a pass is a timeline. Clear is one cycle after START is
    // seen idle, feeding follows, each beat's result is due PIPE_LAT
    // cycles after it was accepted, DONE comes the cycle after the last.
    int           nu[2] = '{2, 4};
    int           pl[2] = '{3, 1};
    bit           act[2];
    int           tclr[2];
    int           acc[2];
    int           outs[2];
    int           tdone[2];
    int           ht[2][8];
    logic [W-1:0] esc[2];
    int           stall[2];

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)",
                     tag, got, exp, cyc);
        end
    endtask

    task automatic step(input int d, input logic rdy, input logic clr,
                        input logic ov, input logic busy,
                        input logic done, input logic [W-1:0] sc,
                        input logic [W-1:0] od, input logic [7:0] ix,
                        input logic [15:0] st);
        string p;
        bit    e_clr, e_rdy, e_ov, e_done;
        p = $sformatf("d%0d_", d);
        if (RESET) begin
            chk({p, "rst_clr"}, clr, 1);
            chk({p, "rst_rdy"}, rdy, 0);
            chk({p, "rst_ov"}, ov, 0);
            chk({p, "rst_busy"}, busy, 0);
            chk({p, "rst_done"}, done, 0);
            chk({p, "rst_sc"}, sc, 0);
            chk({p, "rst_od"}, od, 0);
            chk({p, "rst_ix"}, ix, 0);
`ifdef BWD_CTRL_STALL_CNT_EN
            chk({p, "rst_stall"}, st, 0);
`endif
            act[d]   = 0;
            acc[d]   = 0;
            outs[d]  = 0;
            tdone[d] = -1;
            esc[d]   = '0;
            stall[d] = 0;
            return;
        end
        e_clr  = act[d] && cyc == tclr[d];
        e_rdy  = act[d] && cyc > tclr[d] && acc[d] < nu[d];
        e_ov   = outs[d] < acc[d] && ht[d][outs[d]] + pl[d] == cyc;
        e_done = act[d] && cyc == tdone[d];
        chk({p, "clr"}, clr, e_clr);
        chk({p, "rdy"}, rdy, e_rdy);
        chk({p, "ov"}, ov, e_ov);
        chk({p, "busy"}, busy, act[d]);
        chk({p, "done"}, done, e_done);
        chk({p, "scaler"}, sc, esc[d]);
        if (e_ov) begin
            chk({p, "odata"}, od, ENG_RESULT);
            chk({p, "oindex"}, ix, outs[d]);
        end
`ifdef BWD_CTRL_STALL_CNT_EN
        chk({p, "stall"}, st, stall[d]);
`endif
        if (e_ov) begin
            outs[d]++;
            if (outs[d] == nu[d]) tdone[d] = cyc + 1;
        end
        if (e_clr) stall[d] = 0;
        else if (e_rdy && !IN_VALID && stall[d] < 65535) stall[d]++;
        if (e_rdy && IN_VALID) begin
            ht[d][acc[d]] = cyc;
            acc[d]++;
            esc[d] = IN_DATA;
        end
        if (e_done) begin
            act[d] = 0;
        end else if (!act[d] && START) begin
            act[d]   = 1;
            tclr[d]  = cyc + 1;
            acc[d]   = 0;
            outs[d]  = 0;
            tdone[d] = -1;
        end
    endtask

    always @(negedge CLK) begin
        step(0, rdy0, clr0, ov0, busy0, done0, sc0, od0, 8'(ix0), st0);
        step(1, rdy1, clr1, ov1, busy1, done1, sc1, od1, 8'(ix1), st1);
        cyc++;
    end

    task automatic tick();
        @(posedge CLK);
        #1;
        ENG_RESULT = W'({$urandom(), $urandom()});
    endtask

    task automatic wait_idle(input int bound);
        int n = 0;
        while ((busy0 || busy1) && n < bound) begin
            tick();
            n++;
        end
        chk("idle_timeout", busy0 | busy1, 0);
    endtask

    task automatic begin_pass();
        START = 1'b1;
        tick();
        START = 1'b0;
        IN_VALID = 1'b0;
        tick();
    endtask

    initial begin
        int n;
        repeat (3) tick();
        RESET = 1'b0;
        tick();

        // continuous input, data 1,2,3,4
        begin_pass();
        for (int k = 0; k < 4; k++) begin
            IN_VALID = 1'b1;
            IN_DATA = W'(k + 1);
            tick();
        end
        IN_VALID = 1'b0;
        wait_idle(50);
        tick();

        // four-cycle gaps between beats, scrambled data meanwhile
        begin_pass();
        for (int b = 0; b < 4; b++) begin
            IN_VALID = 1'b1;
            IN_DATA = W'(8'h11 * (b + 1));
            tick();
            IN_VALID = 1'b0;
            if (b < 3) begin
                for (int g = 0; g < 4; g++) begin
                    IN_DATA = W'($urandom());
                    tick();
                end
            end
        end
        wait_idle(50);
        tick();

        // START held through FEED, DRAIN and the DONE cycle
        begin_pass();
        START = 1'b1;
        for (int k = 0; k < 6; k++) begin
            IN_VALID = (k < 4);
            IN_DATA = W'($urandom());
            tick();
        end
        START = 1'b0;
        IN_VALID = 1'b0;
        wait_idle(50);
        tick();

        // reset in DRAIN after the first result of instance 0
        begin_pass();
        for (int k = 0; k < 4; k++) begin
            IN_VALID = 1'b1;
            IN_DATA = W'(k + 5);
            tick();
        end
        IN_VALID = 1'b0;
        n = 0;
        while (!ov0 && n < 20) begin
            tick();
            n++;
        end
        chk("first_out_timeout", ov0, 1);
        tick();
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        begin_pass();
        for (int k = 0; k < 4; k++) begin
            IN_VALID = 1'b1;
            IN_DATA = W'(k + 9);
            tick();
        end
        IN_VALID = 1'b0;
        wait_idle(50);
        tick();

        // random traffic with occasional resets
        for (int k = 0; k < 600; k++) begin
            START = ($urandom_range(0, 5) == 0);
            IN_VALID = ($urandom_range(0, 3) != 0);
            IN_DATA = W'({$urandom(), $urandom()});
            RESET = ($urandom_range(0, 149) == 0);
            tick();
        end
        START = 1'b0;
        IN_VALID = 1'b0;
        RESET = 1'b0;
        tick();
        wait_idle(100);
        tick();

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
